seq_gen_prog: RTL
=================

Name: seq_gen_prog

Overview:
Programmable serial pattern generator. It is the parametrised successor of the fixed 10-step sequence generator.
- Holds a runtime-loadable pattern of up to MAX_LEN bits and a runtime-loadable length.
- Shifts the pattern out LSB-first on Z, one bit per enabled CLK edge.
- Supports free-running repeat mode and triggered one-shot mode, with valid, start-of-sequence and done flags.
- Used wherever lab designs need a configurable bit-stream source, e.g. as a stimulus for sequence detectors.

Parameters:
MAX_LEN, 16, maximum pattern length in bits (2..32).
LEN_W, $clog2(MAX_LEN+1), width of the length field.
PTR_W, $clog2(MAX_LEN), width of the bit pointer.
DEF_LEN, 10, length loaded at reset.
DEF_PAT, 16'h028B, pattern loaded at reset. Bit i is emitted at step i, giving 1,1,0,1,0,0,0,1,0,1.

Ports:
CLK  in  1  clock; all state changes on posedge.
RST  in  1  reset; asynchronous, active-high.
EN  in  1  advance enable; when low, all sequencing state holds.
MODE  in  1  0 = repeat (free-run), 1 = one-shot.
START  in  1  one-shot trigger, sampled in IDLE only.
LOAD  in  1  load request for PAT_IN/LEN_IN.
PAT_IN  in  MAX_LEN  new pattern; bit i is step i.
LEN_IN  in  LEN_W  new length; legal range 1..MAX_LEN.
Z  out  1  registered serial output.
VALID  out  1  Z carries a pattern bit this cycle.
SOS  out  1  Z is step 0 of a pass.
DONE  out  1  1-cycle pulse with the last bit of a one-shot pass.
ERR  out  1  1-cycle pulse when a LOAD has an illegal length.

Behaviour:
- Reset (RST=1, immediate, no clock needed):
  - pat=DEF_PAT, len=DEF_LEN, ptr=0, state=IDLE.
  - Z=0, VALID=0, SOS=0, DONE=0, ERR=0.
- All outputs are registered. DONE and ERR default to 0 every edge unless set below.
- FSM has two states, IDLE and RUN.
- Priority at each edge: LOAD > EN=0 hold > sequencing.
- LOAD=1 with 1<=LEN_IN<=MAX_LEN:
  - pat<=PAT_IN, len<=LEN_IN, ptr<=0, state<=IDLE.
  - VALID<=0, SOS<=0, Z<=0.
  - Aborts any pass in progress without a DONE pulse. A simultaneous START is ignored.
- LOAD=1 with LEN_IN=0 or LEN_IN>MAX_LEN:
  - ERR<=1.
  - pat, len, ptr, state and Z unchanged; sequencing continues as if LOAD=0.
- EN=0 (no LOAD): state, ptr and Z hold; VALID<=0, SOS<=0.
- IDLE, EN=1, trigger present (MODE=0, or MODE=1 with START=1):
  - Emit step 0: Z<=pat[0], VALID<=1, SOS<=1.
  - If len=1, apply the end-of-pass rule below instead.
  - Otherwise ptr<=1, state<=RUN.
  - Latency: first bit is visible after the trigger edge.
- IDLE without a trigger: Z<=0, VALID<=0.
- RUN, EN=1:
  - Z<=pat[ptr], VALID<=1, SOS<=(ptr==0).
  - If ptr==len-1 (end of pass):
    - MODE=0: ptr<=0, stay in RUN. The next bit is step 0 with no gap.
    - MODE=1: ptr<=0, state<=IDLE, DONE<=1 in the same cycle as the last bit.
  - Otherwise ptr<=ptr+1.
- MODE is sampled only at end-of-pass and in IDLE. Changing it mid-pass takes effect at the wrap.
- START while in RUN is ignored.
- Illegal-state recovery: if ptr>=len or the state encoding is illegal, the next enabled edge forces ptr<=0, state<=IDLE, VALID<=0. No X propagation.
- Bits of pat above len-1 are never emitted.

Decomposition:
- Shared package seq_pkg holds:
  - state enum {IDLE, RUN}
  - constants MODE_REPEAT=1'b0, MODE_ONESHOT=1'b1
  - default pattern/length constants for the lab sequence (16'h028B, 10)
- One natural sub-module, seq_ptr_cnt: a wrap-at-len pointer counter with enable, clear and a terminal-count output, reusable by future detectors.
- The FSM and output registers stay in seq_gen_prog.

Test Plan:
1. Reset release, MODE=0, EN=1 held -> Z = 1,1,0,1,0,0,0,1,0,1 repeating for 30 cycles; SOS high on cycles 1, 11, 21; VALID stays high; DONE never pulses.
2. LOAD PAT_IN=16'h0006, LEN_IN=4 while running -> pass aborts; Z = 0,1,1,0 repeating; SOS every 4th cycle.
3. MODE=1, START pulse in IDLE -> exactly 10 valid bits of the default pattern; DONE high with the 10th bit; VALID=0 afterwards; a START during the pass is ignored.
4. EN deasserted at step 4 for 3 cycles -> Z holds its value with VALID=0; resumes at step 5 with the sequence intact.
5. LOAD with LEN_IN=0, then LEN_IN=17 -> ERR pulses each time; output stream is unchanged and uninterrupted.
6. RST asserted asynchronously mid-pass, between clock edges -> Z, VALID, SOS and DONE go to 0 immediately; after release the default pattern restarts at step 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the serial sequence generator family.
package seq_pkg;

    // Sequencer FSM states
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // MODE input encodings
    localparam logic MODE_REPEAT  = 1'b0;
    localparam logic MODE_ONESHOT = 1'b1;

    // Classic lab sequence 1,1,0,1,0,0,0,1,0,1 (bit i is emitted at step i)
    localparam logic [15:0] LAB_PAT = 16'h028B;
    localparam int          LAB_LEN = 10;

    // A length is usable only if it selects at least one bit and fits the pattern register
    function automatic logic len_ok(input int unsigned len, input int unsigned max_len);
        return (len >= 1) && (len <= max_len);
    endfunction

endpackage

// File: rtl/seq_ptr_cnt.sv
// Wrap-at-len bit pointer: counts 0..len-1 while enabled, flags the last
// position (tc) and any out-of-range value (ovr) so the owner can recover.
module seq_ptr_cnt #(
    parameter int PTR_W = 4,
    parameter int LEN_W = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clr,
    input  logic             en,
    input  logic [LEN_W-1:0] len,
    output logic [PTR_W-1:0] ptr,
    output logic             tc,
    output logic             ovr
);

    logic [LEN_W-1:0] ptr_ext;

    assign ptr_ext = LEN_W'(ptr);
    assign tc      = (ptr_ext == len - LEN_W'(1));
    assign ovr     = (ptr_ext >= len);

    // Pointer register: clear wins, otherwise advance and wrap after the terminal count
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: sequential state is updated with non-blocking assignments so every
        // register samples pre-edge values, matching the hardware regardless of block order.
        if (RST) begin
            ptr <= '0;
        end else if (clr) begin
            ptr <= '0;
        end else if (en) begin
            ptr <= tc ? '0 : ptr + PTR_W'(1);
        end
    end

endmodule

// File: rtl/seq_gen_prog.sv
// Programmable serial pattern generator: shifts a loadable pattern out LSB-first
// on Z, either free-running (repeat) or one pass per START (one-shot).
module seq_gen_prog
    import seq_pkg::*;
#(
    parameter int                 MAX_LEN = 16,
    parameter int                 LEN_W   = $clog2(MAX_LEN + 1),
    parameter int                 PTR_W   = $clog2(MAX_LEN),
    parameter int                 DEF_LEN = LAB_LEN,
    parameter logic [MAX_LEN-1:0] DEF_PAT = MAX_LEN'(LAB_PAT)
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               EN,
    input  logic               MODE,
    input  logic               START,
    input  logic               LOAD,
    input  logic [MAX_LEN-1:0] PAT_IN,
    input  logic [LEN_W-1:0]   LEN_IN,
    output logic               Z,
    output logic               VALID,
    output logic               SOS,
    output logic               DONE,
    output logic               ERR
);

    state_t             state;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   len;
    logic [PTR_W-1:0]   ptr;
    logic               ptr_tc;
    logic               ptr_ovr;
    logic               load_ok;
    logic               trigger;
    logic               state_ok;
    logic               cnt_clr;
    logic               cnt_en;

    // Edge-by-edge control decode shared by the pointer counter and the FSM
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        load_ok  = LOAD && len_ok(32'(LEN_IN), MAX_LEN);
        trigger  = (MODE == MODE_REPEAT) || START;
        state_ok = (state == IDLE) || (state == RUN);
        cnt_clr  = 1'b0;
        cnt_en   = 1'b0;
        if (load_ok) begin
            cnt_clr = 1'b1;
        end else if (EN) begin
            if (ptr_ovr || !state_ok) begin
                cnt_clr = 1'b1;
            end else if ((state == RUN) || trigger) begin
                // In IDLE the pointer sits at 0, so advancing emits step 0 and
                // the terminal count covers the single-bit pattern.
                cnt_en = 1'b1;
            end
        end
    end

    seq_ptr_cnt #(
        .PTR_W (PTR_W),
        .LEN_W (LEN_W)
    ) u_ptr (
        .CLK (CLK),
        .RST (RST),
        .clr (cnt_clr),
        .en  (cnt_en),
        .len (len),
        .ptr (ptr),
        .tc  (ptr_tc),
        .ovr (ptr_ovr)
    );

    // Pattern/length registers, sequencing FSM and registered outputs
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pat   <= DEF_PAT;
            len   <= LEN_W'(DEF_LEN);
            state <= IDLE;
            Z     <= 1'b0;
            VALID <= 1'b0;
            SOS   <= 1'b0;
            DONE  <= 1'b0;
            ERR   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            ERR  <= 1'b0;
            if (load_ok) begin
                // A good load aborts the current pass silently and waits in IDLE
                pat   <= PAT_IN;
                len   <= LEN_IN;
                state <= IDLE;
                Z     <= 1'b0;
                VALID <= 1'b0;
                SOS   <= 1'b0;
            end else begin
                // A bad load only flags the error; sequencing carries on untouched
                if (LOAD) begin
                    ERR <= 1'b1;
                end
                if (!EN) begin
                    VALID <= 1'b0;
                    SOS   <= 1'b0;
                end else if (ptr_ovr || !state_ok) begin
                    state <= IDLE;
                    Z     <= 1'b0;
                    VALID <= 1'b0;
                    SOS   <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            if (trigger) begin
                                Z     <= pat[0];
                                VALID <= 1'b1;
                                SOS   <= 1'b1;
                                if (ptr_tc && (MODE == MODE_ONESHOT)) begin
                                    state <= IDLE;
                                    DONE  <= 1'b1;
                                end else begin
                                    state <= RUN;
                                end
                            end else begin
                                Z     <= 1'b0;
                                VALID <= 1'b0;
                                SOS   <= 1'b0;
                            end
                        end
                        RUN: begin
                            Z     <= pat[ptr];
                            VALID <= 1'b1;
                            SOS   <= (ptr == '0);
                            if (ptr_tc && (MODE == MODE_ONESHOT)) begin
                                state <= IDLE;
                                DONE  <= 1'b1;
                            end
                        end
                        default: begin
                            state <= IDLE;
                            Z     <= 1'b0;
                            VALID <= 1'b0;
                            SOS   <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule
